// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: end-of-test monitor on the core fetch port with a sticky pass/fail/timeout verdict.
// Ports: clk_i, rst_i (sync, active-high), enable_i; fetch snoop mem_i_rd_i/mem_i_accept_i/mem_i_pc_i;
// compare operands cmp_a_i/cmp_b_i; verdict done_o/pass_o/fail_o/status_o; counters cycle_count_o,
// fetch_count_o, last_pc_o, pc_change_o. Optional stall verdict: RISCV_TEST_MONITOR_STALL_DETECT_EN.
module riscv_test_monitor #(
  parameter logic [31:0] PASS_PC        = 32'h8000012c,
  parameter logic [31:0] FAIL_PC        = 32'h80000130,
  parameter int          TIMEOUT_CYCLES = 2000,
  parameter int          CYCLE_W        = 32,
  parameter int          STALL_CYCLES   = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               mem_i_rd_i,
  input  logic               mem_i_accept_i,
  input  logic [31:0]        mem_i_pc_i,
  input  logic [31:0]        cmp_a_i,
  input  logic [31:0]        cmp_b_i,
  output logic               done_o,
  output logic               pass_o,
  output logic               fail_o,
  output logic [2:0]         status_o,
  output logic [CYCLE_W-1:0] cycle_count_o,
  output logic [31:0]        fetch_count_o,
  output logic [31:0]        last_pc_o,
  output logic               pc_change_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;
  state_t state;
  logic fire, pass_hit, fail_hit, tmo_hit, stall_hit, cmp_eq;
  logic [CYCLE_W-1:0] cyc_next;
  assign fire     = mem_i_rd_i & mem_i_accept_i;
  assign pass_hit = fire && mem_i_pc_i == PASS_PC;
  assign fail_hit = fire && mem_i_pc_i == FAIL_PC && !pass_hit;
  assign tmo_hit  = cycle_count_o == CYCLE_W'(TIMEOUT_CYCLES - 1);
  assign cmp_eq   = cmp_a_i == cmp_b_i;
  assign cyc_next = &cycle_count_o ? cycle_count_o : cycle_count_o + CYCLE_W'(1);
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
  localparam int IW = $clog2(STALL_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
  assign stall_hit = !fire && idle_cnt == IW'(STALL_CYCLES - 1);
`else
  // No idle counter in this build, so the stall verdict can never be taken.
  assign stall_hit = STALL_CYCLES < 0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      status_o      <= 3'd0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      fail_o        <= 1'b0;
      cycle_count_o <= '0;
      fetch_count_o <= '0;
      last_pc_o     <= '0;
      pc_change_o   <= 1'b0;
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
      idle_cnt      <= '0;
`endif
    end else begin
      pc_change_o <= 1'b0;
      case (state)
        S_IDLE: if (enable_i) begin
          state    <= S_RUN;
          status_o <= 3'd1;
        end
        S_RUN: if (enable_i) begin
          cycle_count_o <= cyc_next;
          if (fire) begin
            fetch_count_o <= fetch_count_o + 32'd1;
            last_pc_o     <= mem_i_pc_i;
            // A pass hit enters DONE directly, where pc_change_o must stay low.
            pc_change_o   <= mem_i_pc_i != last_pc_o && !pass_hit;
          end
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
          idle_cnt <= fire ? '0 : idle_cnt + IW'(1);
`endif
          if (pass_hit) begin
            state    <= S_DONE;
            status_o <= 3'd2;
            done_o   <= 1'b1;
            pass_o   <= 1'b1;
          end else if (fail_hit) begin
            state <= S_CHECK;
          end else if (tmo_hit || stall_hit) begin
            state    <= S_DONE;
            status_o <= tmo_hit ? 3'd5 : 3'd6;
            done_o   <= 1'b1;
            fail_o   <= 1'b1;
          end
        end
        // One settle cycle for the register write-back before comparing.
        S_CHECK: begin
          cycle_count_o <= cyc_next;
          state         <= S_DONE;
          status_o      <= cmp_eq ? 3'd3 : 3'd4;
          done_o        <= 1'b1;
          pass_o        <= cmp_eq;
          fail_o        <= !cmp_eq;
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: table-driven and directed checks of riscv_test_monitor.
module tb_riscv_test_monitor;
  localparam logic [31:0] PASS = 32'h8000012c;
  localparam logic [31:0] FAILPC = 32'h80000130;
  localparam logic [31:0] BASE = 32'h80000000;
  localparam int TMO = 100;
  localparam int STALL = 8;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, rd = 1'b0, acc = 1'b0;
  logic [31:0] pc = '0, a = '0, b = '0;
  logic done_o, pass_o, fail_o, pc_change_o;
  logic [2:0] status_o;
  logic [31:0] cycle_count_o, fetch_count_o, last_pc_o;
  int checks = 0, errors = 0;
  riscv_test_monitor #(.PASS_PC(PASS), .FAIL_PC(FAILPC), .TIMEOUT_CYCLES(TMO), .CYCLE_W(32),
                       .STALL_CYCLES(STALL)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .mem_i_rd_i(rd), .mem_i_accept_i(acc),
    .mem_i_pc_i(pc), .cmp_a_i(a), .cmp_b_i(b), .done_o(done_o), .pass_o(pass_o),
    .fail_o(fail_o), .status_o(status_o), .cycle_count_o(cycle_count_o),
    .fetch_count_o(fetch_count_o), .last_pc_o(last_pc_o), .pc_change_o(pc_change_o));
  always #5 clk = ~clk;
  typedef struct {
    logic en, rd, acc;
    logic [31:0] pc, a, b;
    logic [2:0] st;
    logic [31:0] cyc, fc, lpc;
    logic pcc;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic e, d, c, input logic [31:0] p, ca, cb, input logic [2:0] st,
                     input logic [31:0] cyc, fc, lpc, input logic pcc);
    vec_t v;
    v.en = e; v.rd = d; v.acc = c; v.pc = p; v.a = ca; v.b = cb;
    v.st = st; v.cyc = cyc; v.fc = fc; v.lpc = lpc; v.pcc = pcc;
    tv.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic chk_state(input string t, input logic [2:0] st, input logic [31:0] cyc, fc, lpc,
                           input logic pcc);
    chk({t, ".status"}, 32'(status_o), 32'(st));
    chk({t, ".done"}, 32'(done_o), 32'(st >= 3'd2));
    chk({t, ".pass"}, 32'(pass_o), 32'(st == 3'd2 || st == 3'd3));
    chk({t, ".fail"}, 32'(fail_o), 32'(st >= 3'd4));
    chk({t, ".cycles"}, cycle_count_o, cyc);
    chk({t, ".fetches"}, fetch_count_o, fc);
    chk({t, ".last_pc"}, last_pc_o, lpc);
    chk({t, ".pc_change"}, 32'(pc_change_o), 32'(pcc));
  endtask
  task automatic step(input logic r, e, d, c, input logic [31:0] p, ca, cb);
    rst = r; en = e; rd = d; acc = c; pc = p; a = ca; b = cb;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_run();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask
  initial begin
    step(1'b1, 1'b1, 1'b1, 1'b1, PASS, '0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b1, FAILPC, '0, '0);
    chk_state("reset", 3'd0, 0, 0, 0, 1'b0);
    // pause, non-accepted PASS fetch, pc_change pulses, CHECK with equal operands
    add(1'b1, 1'b0, 1'b0, '0, '0, '0, 3'd1, 32'd0, 32'd0, 32'h0, 1'b0);
    add(1'b1, 1'b1, 1'b1, BASE, '0, '0, 3'd1, 32'd1, 32'd1, BASE, 1'b1);
    add(1'b1, 1'b1, 1'b1, BASE, '0, '0, 3'd1, 32'd2, 32'd2, BASE, 1'b0);
    add(1'b1, 1'b1, 1'b0, PASS, '0, '0, 3'd1, 32'd3, 32'd2, BASE, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 1'b1, 1'b1, BASE + 32'h10, '0, '0, 3'd1, 32'd3, 32'd2, BASE, 1'b0);
    add(1'b1, 1'b1, 1'b1, BASE + 32'h10, '0, '0, 3'd1, 32'd4, 32'd3, BASE + 32'h10, 1'b1);
    add(1'b1, 1'b1, 1'b1, BASE + 32'h14, '0, '0, 3'd1, 32'd5, 32'd4, BASE + 32'h14, 1'b1);
    add(1'b1, 1'b0, 1'b0, '0, '0, '0, 3'd1, 32'd6, 32'd4, BASE + 32'h14, 1'b0);
    add(1'b1, 1'b1, 1'b1, FAILPC, 32'd42, 32'd42, 3'd1, 32'd7, 32'd5, FAILPC, 1'b1);
    add(1'b1, 1'b1, 1'b1, PASS, 32'd42, 32'd42, 3'd3, 32'd8, 32'd5, FAILPC, 1'b0);
    add(1'b1, 1'b1, 1'b1, BASE, 32'd1, 32'd2, 3'd3, 32'd8, 32'd5, FAILPC, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    foreach (tv[i]) begin
      step(1'b0, tv[i].en, tv[i].rd, tv[i].acc, tv[i].pc, tv[i].a, tv[i].b);
      chk_state($sformatf("vec%0d", i), tv[i].st, tv[i].cyc, tv[i].fc, tv[i].lpc, tv[i].pcc);
    end
    // full pass run: 76 sequential fetches ending at PASS_PC, then frozen
    reset_run();
    for (int i = 0; i < 76; i++) step(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'(i * 4), '0, '0);
    chk_state("pass_run", 3'd2, 32'd76, 32'd76, PASS, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, BASE, '0, '0);
    chk_state("pass_frozen", 3'd2, 32'd76, 32'd76, PASS, 1'b0);
    // compare override fails; CHECK samples operands even with enable low
    reset_run();
    step(1'b0, 1'b1, 1'b1, 1'b1, FAILPC, 32'd41, 32'd42);
    chk_state("check", 3'd1, 32'd1, 32'd1, FAILPC, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 32'd41, 32'd42);
    chk_state("fail_ovr", 3'd4, 32'd2, 32'd1, FAILPC, 1'b0);
    // timeout
    reset_run();
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b1, 1'b1, 1'b1, BASE, '0, '0);
    chk_state("pre_tmo", 3'd1, 32'(TMO - 1), 32'(TMO - 1), BASE, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, BASE, '0, '0);
    chk_state("tmo", 3'd5, 32'(TMO), 32'(TMO), BASE, 1'b0);
    // PASS_PC on the timeout cycle wins
    reset_run();
    for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b1, 1'b1, 1'b1, BASE, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, PASS, '0, '0);
    chk_state("tmo_pass", 3'd2, 32'(TMO), 32'(TMO), PASS, 1'b0);
    // reset during CHECK and during DONE
    reset_run();
    step(1'b0, 1'b1, 1'b1, 1'b1, FAILPC, 32'd42, 32'd42);
    step(1'b1, 1'b1, 1'b1, 1'b1, FAILPC, 32'd42, 32'd42);
    chk_state("rst_check", 3'd0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, PASS, '0, '0);
    chk_state("rerun", 3'd2, 32'd1, 32'd1, PASS, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, PASS, '0, '0);
    chk_state("rst_done", 3'd0, 0, 0, 0, 1'b0);
    // no fetches at all: stall verdict when built in, otherwise timeout
    reset_run();
    begin
      int n = 0;
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
      int exp_n = STALL;
      logic [2:0] exp_st = 3'd6;
`else
      int exp_n = TMO;
      logic [2:0] exp_st = 3'd5;
`endif
      while (!done_o && n < 300) begin
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        n++;
      end
      chk("idle_steps", 32'(n), 32'(exp_n));
      chk_state("idle_end", exp_st, 32'(exp_n), 32'd0, 32'd0, 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
